bank_ctrl: RTL

BANK_CTRL -- requirements
Module: bank_ctrl

---
 rtl/bank_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/bank_ctrl.sv
// Register-bank switch controller with interrupt return stack; ack 1 cycle after sampling, bank change DRAIN_CYC edges later.
// Requests are level-held until ack_o; they are only sampled in IDLE with stall_i low, otherwise ignored.
module bank_ctrl #(
  parameter int BANKS     = 13,
  parameter int DEPTH     = 4,
  parameter int DRAIN_CYC = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       irq_i,
  input  logic [3:0] irq_bank_i,
  input  logic       rti_i,
  input  logic       sw_we_i,
  input  logic [3:0] sw_bank_i,
  input  logic       stall_i,
  input  logic       clr_err_i,
  output logic [3:0] bank_o,
  output logic       busy_o,
  output logic       ack_o,
  output logic [2:0] depth_o,
  output logic       ovf_o,
  output logic       unf_o,
  output logic       inv_o
);

  localparam int         CW        = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [4:0] BANK_LIM  = 5'(BANKS);
  localparam logic [2:0] DEPTH_LIM = 3'(DEPTH);

  typedef enum logic {IDLE, DRAIN} state_t;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic inv;
  } err_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    target;
  logic [3:0]    stack [8];
  err_t          err;
  err_t          err_set;

  logic sample, take_irq, take_rti, take_sw, take_any, accept;
  logic irq_inv, sw_inv;

  // Fixed priority irq > rti > sw; losers simply stay asserted.
  assign sample   = (state == IDLE) && !stall_i;
  assign take_irq = sample && irq_i;
  assign take_rti = sample && !irq_i && rti_i;
  assign take_sw  = sample && !irq_i && !rti_i && sw_we_i;
  assign take_any = take_irq || take_rti || take_sw;

  assign irq_inv = {1'b0, irq_bank_i} >= BANK_LIM;
  assign sw_inv  = {1'b0, sw_bank_i} >= BANK_LIM;

  // Invalid target wins over overflow for an irq.
  assign err_set.inv = (take_irq && irq_inv) || (take_sw && sw_inv);
  assign err_set.ovf = take_irq && !irq_inv && (depth_o == DEPTH_LIM);
  assign err_set.unf = take_rti && (depth_o == 3'd0);
  assign accept      = take_any && !(|err_set);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      target  <= '0;
      bank_o  <= '0;
      busy_o  <= 1'b0;
      ack_o   <= 1'b0;
      depth_o <= '0;
      err     <= '0;
    end else begin
      ack_o <= take_any;
      err   <= err_set | (err & ~{3{clr_err_i}});
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= DRAIN;
            busy_o <= 1'b1;
            cnt    <= CW'(DRAIN_CYC - 1);
            if (take_irq) begin
              depth_o <= depth_o + 3'd1;
              target  <= irq_bank_i;
            end else if (take_rti) begin
              depth_o <= depth_o - 3'd1;
              target  <= stack[depth_o - 3'd1];
            end else begin
              target  <= sw_bank_i;
            end
          end
        end
        DRAIN: begin
          if (cnt == '0) begin
            bank_o <= target;
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stack contents need no reset: depth_o alone defines which entries are live.
  always_ff @(posedge clk_i) begin
    if (rst_i && accept && take_irq) begin
      stack[depth_o] <= bank_o;
    end
  end

  assign ovf_o = err.ovf;
  assign unf_o = err.unf;
  assign inv_o = err.inv;

endmodule
